// File: rtl/conway_pkg.sv
// Shared definitions for the Game-of-Life generation datapath: phase encoding
// and default grid/counter sizes used by the scheduler and the array controller.
package conway_pkg;

  localparam int ROWS_DEF  = 4;
  localparam int GEN_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    STORE = 3'd4
  } state_e;

  // Phases in which the scheduler itself owns the cell memory port.
  function automatic logic is_mem_phase(input state_e s);
    return (s == LOAD) || (s == STORE);
  endfunction

endpackage

// File: rtl/conway_mem_arbiter.sv
// Shares the cell memory between the generation scheduler and the display
// reader: decides when the scheduler must hold back one cycle.
module conway_mem_arbiter
  import conway_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_ni,
  input  state_e state_i,
  input  logic   disp_req_i,
  output logic   stall_o,
  output logic   disp_grant_o
);

  logic prio_q;
  logic prio_d;
  logic mem_due;

  // SETUP and RUN always advance into a memory phase unless stalled.
  assign mem_due      = (state_i == SETUP) || (state_i == RUN);
  assign stall_o      = mem_due && disp_req_i && prio_q;
  assign disp_grant_o = disp_req_i && !is_mem_phase(state_i);

  // A stall yields once; the next memory phase entered hands priority back.
  always_comb begin
    prio_d = prio_q;
    if (stall_o) begin
      prio_d = 1'b0;
    end else if (mem_due) begin
      prio_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/conway_gen_scheduler.sv
// Steps the row position through SETUP/LOAD/RUN/STORE for one Game-of-Life
// generation, counts completed generations, and yields memory to the display.
module conway_gen_scheduler
  import conway_pkg::*;
#(
  parameter int ROWS  = ROWS_DEF,
  parameter int POS_W = $clog2(ROWS),
  parameter int GEN_W = GEN_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             continuous,
  input  logic             halt,
  input  logic             disp_req,
  output logic             disp_grant,
  output logic             write_array,
  output logic             run,
  output logic             write_mem,
  output logic [POS_W-1:0] pos,
  output logic             busy,
  output logic             gen_done,
  output logic [GEN_W-1:0] generation
);

  state_e             state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [GEN_W-1:0]   gen_q, gen_d;
  logic               done_q, done_d;
  logic               halt_q, halt_d;
  logic               stall;
  logic               last_row;
  logic               halt_seen;

  conway_mem_arbiter u_arb (
    .clk_i        (clk),
    .rst_ni       (reset),
    .state_i      (state_q),
    .disp_req_i   (disp_req),
    .stall_o      (stall),
    .disp_grant_o (disp_grant)
  );

  assign last_row  = (pos_q == POS_W'(ROWS - 1));
  // A halt raised in the final STORE still counts as a request for this generation.
  assign halt_seen = halt_q || halt;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    gen_d   = gen_q;
    done_d  = 1'b0;
    halt_d  = halt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          pos_d   = '0;
        end
      end
      SETUP: begin
        if (!stall) state_d = LOAD;
      end
      LOAD: begin
        state_d = RUN;
      end
      RUN: begin
        if (!stall) state_d = STORE;
      end
      STORE: begin
        if (!last_row) begin
          pos_d   = pos_q + 1'b1;
          state_d = SETUP;
        end else begin
          pos_d   = '0;
          gen_d   = gen_q + 1'b1;
          done_d  = 1'b1;
          state_d = (continuous && !halt_seen) ? SETUP : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (state_q != IDLE) halt_d = halt_seen;
    if (state_d == IDLE) halt_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pos_q   <= '0;
      gen_q   <= '0;
      done_q  <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      gen_q   <= gen_d;
      done_q  <= done_d;
      halt_q  <= halt_d;
    end
  end

  assign write_array = (state_q == LOAD);
  assign run         = (state_q == RUN);
  assign write_mem   = (state_q == STORE);
  assign busy        = (state_q != IDLE);
  assign pos         = pos_q;
  assign gen_done    = done_q;
  assign generation  = gen_q;

endmodule
